// File: rtl/io_arb_pkg.sv
// Shared definitions for the two-port IO bus arbiter: state encoding and bus widths.
package io_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned IO_AW = 8;
  localparam int unsigned IO_DW = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_BUS  = S_BUS,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the IO peripheral bus between the MMU port (0) and a
// secondary master (1); each access is held for WAIT_CYCLES (1..15) and ends with a done pulse.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [IO_AW-1:0] addr0,
  input  logic [IO_AW-1:0] addr1,
  input  logic [IO_DW-1:0] wdata0,
  input  logic [IO_DW-1:0] wdata1,
  output logic             done0,
  output logic             done1,
  output logic [IO_DW-1:0] rdata0,
  output logic [IO_DW-1:0] rdata1,
  output logic             busy,
  output logic [IO_AW-1:0] io_addr,
  output logic             io_en,
  output logic             io_we,
  output logic [IO_DW-1:0] io_data_write,
  input  logic [IO_DW-1:0] io_data_read
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_gnt;
  logic               r_last_gnt;

  logic               w_any_req;
  logic               w_pick1;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign w_any_req = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_last_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_gnt         <= 1'b0;
      r_last_gnt    <= 1'b1;
      done0         <= 1'b0;
      done1         <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      busy          <= 1'b0;
      io_addr       <= '0;
      io_en         <= 1'b0;
      io_we         <= 1'b0;
      io_data_write <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt         <= w_pick1;
            r_last_gnt    <= w_pick1;
            io_we         <= w_pick1 ? we1    : we0;
            io_addr       <= w_pick1 ? addr1  : addr0;
            io_data_write <= w_pick1 ? wdata1 : wdata0;
            r_cnt         <= CNT_W'(WAIT_CYCLES - 1);
            io_en         <= 1'b1;
            busy          <= 1'b1;
            r_state       <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (r_cnt == '0) begin
            // Last strobe cycle: capture read data for the granted port only.
            if (!io_we) begin
              if (r_gnt) rdata1 <= io_data_read;
              else       rdata0 <= io_data_read;
            end
            io_en   <= 1'b0;
            io_we   <= 1'b0;
            done0   <= ~r_gnt;
            done1   <= r_gnt;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Bench for io_arbiter: per-cycle vector table on a WAIT_CYCLES=1 instance, plus
// hand sequences on a WAIT_CYCLES=3 instance for sampling, input hold and reset abort.
module tb_io_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [7:0]  a0, a1;
  logic [31:0] wd0, wd1, rd;

  logic        d0_1, d1_1, busy_1, en_1, we_1;
  logic [31:0] r0_1, r1_1, wdo_1;
  logic [7:0]  addr_1;
  logic        d0_3, d1_3, busy_3, en_3, we_3;
  logic [31:0] r0_3, r1_3, wdo_3;
  logic [7:0]  addr_3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(a0), .addr1(a1), .wdata0(wd0), .wdata1(wd1),
    .done0(d0_1), .done1(d1_1), .rdata0(r0_1), .rdata1(r1_1), .busy(busy_1),
    .io_addr(addr_1), .io_en(en_1), .io_we(we_1), .io_data_write(wdo_1),
    .io_data_read(rd)
  );

  io_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(a0), .addr1(a1), .wdata0(wd0), .wdata1(wd1),
    .done0(d0_3), .done1(d1_3), .rdata0(r0_3), .rdata1(r1_3), .busy(busy_3),
    .io_addr(addr_3), .io_en(en_3), .io_we(we_3), .io_data_write(wdo_3),
    .io_data_read(rd)
  );

  typedef struct {
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [7:0]  a0, a1;
    logic [31:0] wd0, wd1, rd;
    logic        e_en, e_we, e_d0, e_d1, e_busy;
    logic [7:0]  e_addr;
    logic [31:0] e_wd, e_r0, e_r1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst1 io_en", 32'(en_1), 32'd0);
    chk("rst1 io_we", 32'(we_1), 32'd0);
    chk("rst1 busy", 32'(busy_1), 32'd0);
    chk("rst1 done0", 32'(d0_1), 32'd0);
    chk("rst1 done1", 32'(d1_1), 32'd0);
    chk("rst1 io_addr", 32'(addr_1), 32'd0);
    chk("rst1 io_data_write", wdo_1, 32'd0);
    chk("rst1 rdata0", r0_1, 32'd0);
    chk("rst1 rdata1", r1_1, 32'd0);
    chk("rst3 io_en", 32'(en_3), 32'd0);
    chk("rst3 busy", 32'(busy_3), 32'd0);
    chk("rst3 rdata1", r1_3, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_r1;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; rd = '0;

    // Single read on port 0 straight after reset.
    v = '{default: '0};
    v.rst = 1'b1; v.req0 = 1'b1; v.a0 = 8'h10; v.rd = 32'hDEADBEEF;
    v.e_en = 1'b1; v.e_addr = 8'h10; v.e_busy = 1'b1;
    vecs.push_back(v);
    v.rst = 1'b0; v.e_en = 1'b0; v.e_d0 = 1'b1; v.e_r0 = 32'hDEADBEEF;
    vecs.push_back(v);
    v.req0 = 1'b0; v.e_d0 = 1'b0; v.e_busy = 1'b0;
    vecs.push_back(v);
    vecs.push_back(v);

    // Continuous contention: port 0 writes 0x1234 to 0x04, port 1 reads 0x08.
    exp_r1 = '0;
    for (int k = 0; k < 18; k++) begin
      int   ph;
      logic p;
      ph = k % 3;
      p  = ((k / 3) % 2) == 1;
      v = '{default: '0};
      v.rst = (k == 0);
      v.req0 = 1'b1; v.req1 = 1'b1; v.we0 = 1'b1; v.we1 = 1'b0;
      v.a0 = 8'h04; v.a1 = 8'h08; v.wd0 = 32'h1234; v.wd1 = 32'h55;
      v.rd = 32'hB000_0000 + 32'(k);
      v.e_addr = p ? 8'h08 : 8'h04;
      v.e_wd   = p ? 32'h55 : 32'h1234;
      v.e_en   = (ph == 0);
      v.e_we   = (ph == 0) && !p;
      v.e_d0   = (ph == 1) && !p;
      v.e_d1   = (ph == 1) && p;
      v.e_busy = (ph != 2);
      if (ph == 1 && p) exp_r1 = v.rd;
      v.e_r1 = exp_r1;
      vecs.push_back(v);
    end
    v.req0 = 1'b0; v.req1 = 1'b0; v.rst = 1'b0;
    v.e_en = 1'b0; v.e_we = 1'b0; v.e_d0 = 1'b0; v.e_d1 = 1'b0; v.e_busy = 1'b0;
    vecs.push_back(v);

    tick();
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.rst) do_reset();
      req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
      a0 = v.a0; a1 = v.a1; wd0 = v.wd0; wd1 = v.wd1; rd = v.rd;
      tick();
      chk($sformatf("row%0d io_en", i), 32'(en_1), 32'(v.e_en));
      chk($sformatf("row%0d io_we", i), 32'(we_1), 32'(v.e_we));
      chk($sformatf("row%0d io_addr", i), 32'(addr_1), 32'(v.e_addr));
      chk($sformatf("row%0d io_data_write", i), wdo_1, v.e_wd);
      chk($sformatf("row%0d done0", i), 32'(d0_1), 32'(v.e_d0));
      chk($sformatf("row%0d done1", i), 32'(d1_1), 32'(v.e_d1));
      chk($sformatf("row%0d busy", i), 32'(busy_1), 32'(v.e_busy));
      chk($sformatf("row%0d rdata0", i), r0_1, v.e_r0);
      chk($sformatf("row%0d rdata1", i), r1_1, v.e_r1);
    end

    // WAIT_CYCLES=3 port 1 read: only the last strobe cycle's bus value is kept.
    do_reset();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; a1 = 8'h20; wd1 = '0; rd = '0;
    tick();
    chk("w3 c1 io_en", 32'(en_3), 32'd1);
    chk("w3 c1 io_addr", 32'(addr_3), 32'h20);
    chk("w3 c1 io_we", 32'(we_3), 32'd0);
    rd = 32'h1111_1111;
    tick();
    chk("w3 c2 io_en", 32'(en_3), 32'd1);
    chk("w3 c2 done1", 32'(d1_3), 32'd0);
    rd = 32'h2222_2222;
    tick();
    chk("w3 c3 io_en", 32'(en_3), 32'd1);
    chk("w3 c3 done1", 32'(d1_3), 32'd0);
    rd = 32'h3333_3333;
    tick();
    chk("w3 c4 io_en", 32'(en_3), 32'd0);
    chk("w3 c4 done1", 32'(d1_3), 32'd1);
    chk("w3 c4 done0", 32'(d0_3), 32'd0);
    chk("w3 c4 rdata1", r1_3, 32'h3333_3333);
    req1 = 1'b0; rd = 32'h4444_4444;
    tick();
    chk("w3 c5 done1", 32'(d1_3), 32'd0);
    chk("w3 c5 busy", 32'(busy_3), 32'd0);
    chk("w3 c5 rdata1", r1_3, 32'h3333_3333);

    // Requester changes addr/wdata after grant; bus keeps the captured values.
    req0 = 1'b1; we0 = 1'b1; a0 = 8'h30; wd0 = 32'hCAFE_0001;
    tick();
    chk("hold g io_addr", 32'(addr_3), 32'h30);
    chk("hold g io_data_write", wdo_3, 32'hCAFE_0001);
    chk("hold g io_we", 32'(we_3), 32'd1);
    a0 = 8'h31; wd0 = 32'h0BAD_0BAD; we0 = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      tick();
      chk($sformatf("hold c%0d io_en", c), 32'(en_3), 32'd1);
      chk($sformatf("hold c%0d io_we", c), 32'(we_3), 32'd1);
      chk($sformatf("hold c%0d io_addr", c), 32'(addr_3), 32'h30);
      chk($sformatf("hold c%0d io_data_write", c), wdo_3, 32'hCAFE_0001);
    end
    tick();
    chk("hold done0", 32'(d0_3), 32'd1);
    chk("hold done io_addr", 32'(addr_3), 32'h30);
    chk("hold rdata0", r0_3, 32'd0);
    req0 = 1'b0;
    tick();

    // Reset during BUS aborts the access; afterwards port 0 wins the first tie.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; a0 = 8'h40; a1 = 8'h41;
    tick();
    chk("abort g io_addr", 32'(addr_3), 32'h41);
    chk("abort g io_en", 32'(en_3), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("abort io_en", 32'(en_3), 32'd0);
    chk("abort busy", 32'(busy_3), 32'd0);
    chk("abort done1", 32'(d1_3), 32'd0);
    tick();
    chk("abort hold done0", 32'(d0_3), 32'd0);
    chk("abort hold done1", 32'(d1_3), 32'd0);
    chk("abort hold io_en", 32'(en_3), 32'd0);
    reset = 1'b0;
    tick();
    chk("post g io_en", 32'(en_3), 32'd1);
    chk("post g io_addr", 32'(addr_3), 32'h40);
    tick();
    tick();
    tick();
    chk("post done0", 32'(d0_3), 32'd1);
    chk("post done1", 32'(d1_3), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
# io_arbiter

Two-port arbiter and sequencer for the 8-bit-address memory-mapped IO bus behind the MMU. It shares the single IO peripheral bus between the CPU-side MMU port (port 0) and a secondary bus master such as a debug loader or DMA engine (port 1). Arbitration is round-robin. Each access is captured into registers at grant, driven onto the bus for a fixed number of wait cycles, then completed with a one-cycle done pulse and registered read data.

## Interface
- WAIT_CYCLES, 1: cycles io_en is held per access; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1; held high until that port's done.
- we0 / we1  in  1  write enable of the pending request.
- addr0 / addr1  in  8  IO word address of the pending request.
- wdata0 / wdata1  in  32  write data of the pending request.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data; valid when done is high, held until that port's next done.
- busy  out  1  high in BUS and DONE states.
- io_addr  out  8  bus address.
- io_en  out  1  bus access strobe.
- io_we  out  1  bus write strobe, qualified by io_en.
- io_data_write  out  32  bus write data.
- io_data_read  in  32  bus read data, sampled on the last io_en cycle.

## Operation
- FSM states: IDLE, BUS, DONE. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port not granted last (last_gnt register; reset value 1, so port 0 wins the first tie).
  - On grant: capture that port's we, addr and wdata into io_we, io_addr and io_data_write. Load wait counter with WAIT_CYCLES-1, set io_en, update last_gnt, go to BUS.
- BUS:
  - io_en is high. The counter decrements each cycle.
  - When the counter is 0: sample io_data_read into the granted port's rdata register (reads only; writes leave rdata unchanged). Clear io_en and io_we, pulse the granted port's done, go to DONE.
- DONE:
  - done is high for this cycle only. Requests are ignored, then the FSM returns to IDLE.
  - A req still high in IDLE is a new transaction.
- Requester-side changes to we, addr or wdata after grant have no effect.
- Only one of done0 and done1 is ever high, and never in consecutive cycles.
- Reset asserted mid-access: all registers clear immediately. The access is aborted, no done is produced, and last_gnt returns to 1.

## Timing
- Reset values: io_en, io_we, done0, done1 and busy are 0; io_addr, io_data_write, rdata0 and rdata1 are 0; state is IDLE.
- Access timeline, with req seen high in IDLE at edge N:
  - io_en high for cycles N+1 .. N+WAIT_CYCLES.
  - done high in cycle N+WAIT_CYCLES+1.
  - Back in IDLE at N+WAIT_CYCLES+2.
- Throughput is one access per WAIT_CYCLES+2 cycles. Alternating ports under contention each get every other slot.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- io_addr, io_we and io_data_write are stable for the whole io_en window.

## Structure
- Shared package io_arb_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_BUS=2'd1, S_DONE=2'd2;
  - IO_AW=8 and IO_DW=32.
- Single module; no sub-module. The round-robin pick is a few gates inside the IDLE branch.
- Counter width is 4 bits.

## Test plan
- Reset then single read, port 0: WAIT_CYCLES=1, addr0=8'h10, bus returns 32'hDEADBEEF. Required: io_en high exactly 1 cycle with io_addr=8'h10 and io_we=0; done0 two cycles after the req edge; rdata0=32'hDEADBEEF; done1 never pulses.
- Simultaneous requests from reset: port 0 write 32'h1234 to 8'h04, port 1 read 8'h08. Required: port 0 granted first and io_data_write=32'h1234 with io_we=1; port 1 is granted in the following IDLE; order 0,1.
- Continuous contention for 6 accesses: grant order is 0,1,0,1,0,1 and each done is separated by 3 cycles at WAIT_CYCLES=1.
- WAIT_CYCLES=3, port 1 read: io_en high 3 cycles; data sampled on the 3rd cycle only (bus value changes between cycles 1 and 3, and rdata1 equals the cycle-3 value); done1 at cycle 4.
- Input change after grant: alter addr0 and wdata0 one cycle after the grant. Required: io_addr and io_data_write keep the captured values through the whole access.
- Reset asserted in BUS: io_en falls immediately and no done is produced. After release, simultaneous requests grant port 0 first.
